// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, bit-timing helpers and the parity function.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_hz, input int unsigned baud);
        return cycles_per_bit(clk_hz, baud) / 2;
    endfunction

    // even = 1 gives the bit that makes the total count of ones even
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for asynchronous inputs; all stages reset to 1 (idle-high lines).
module uart_sync #(
    parameter int unsigned p_stages = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d,
    output logic q
);

    logic [p_stages-1:0] sync_ff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[p_stages-2:0], d};
        end
    end

    assign q = sync_ff[p_stages-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, optional parity, 1 or 2 stop bits, mid-bit sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned p_clk_speed_hz = 50_000_000,
    parameter int unsigned p_baud_rate    = 9_600
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic                 enable_i,
    input  logic                 parity_en_i,
    input  logic                 parity_sel_i,
    input  logic                 stop_sel_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int unsigned CYC_PER_BIT = cycles_per_bit(p_clk_speed_hz, p_baud_rate);
    localparam int unsigned HALF_BIT    = half_bit(p_clk_speed_hz, p_baud_rate);
    localparam int unsigned CNT_W       = $clog2(CYC_PER_BIT) + 1;
    localparam int unsigned BIT_CNT_W   = 3;

    localparam logic [CNT_W-1:0]     CNT_BIT_LAST  = CNT_W'(CYC_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST      = BIT_CNT_W'(DATA_BITS - 1);

    uart_state_e            state;
    logic [CNT_W-1:0]       cyc_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_err_acc;
    logic                   frm_err_acc;
    logic                   deliver;
    logic                   rx_s;

    uart_sync #(
        .p_stages (2)
    ) u_rx_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (rx_i),
        .q       (rx_s)
    );

    assign busy_o = (state != ST_IDLE);

    // Frame sequencer; every sample after the start check lands mid-bit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            par_err_acc  <= 1'b0;
            frm_err_acc  <= 1'b0;
            deliver      <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i && !rx_s) begin
                        state   <= ST_START;
                        cyc_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (cyc_cnt == CNT_HALF_LAST) begin
                        cyc_cnt     <= '0;
                        bit_cnt     <= '0;
                        par_err_acc <= 1'b0;
                        frm_err_acc <= 1'b0;
                        state       <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cyc_cnt == CNT_BIT_LAST) begin
                        cyc_cnt        <= '0;
                        shift[bit_cnt] <= rx_s;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= parity_en_i ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cyc_cnt == CNT_BIT_LAST) begin
                        cyc_cnt     <= '0;
                        par_err_acc <= (rx_s != parity_bit(shift, parity_sel_i));
                        state       <= ST_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // deliver holds the frame one cycle after the final stop sample
                    if (deliver) begin
                        deliver      <= 1'b0;
                        bit_cnt      <= '0;
                        data_o       <= shift;
                        parity_err_o <= par_err_acc;
                        frame_err_o  <= frm_err_acc;
                        data_valid_o <= 1'b1;
                        state        <= frm_err_acc ? ST_BREAK : ST_IDLE;
                    end else if (cyc_cnt == CNT_BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (!rx_s) begin
                            frm_err_acc <= 1'b1;
                        end
                        if (stop_sel_i && (bit_cnt == '0)) begin
                            bit_cnt <= BIT_CNT_W'(1);
                        end else begin
                            deliver <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
